// File: rtl/mem_responder.sv
// mem_responder
// Memory-side responder for the Mic-1 datapath. It turns the WRITE/READ/FETCH
// strobes from the register file into cycles on a single-port synchronous RAM.
// Read words come back to MDR and fetched opcode bytes come back to MBR, each
// with a one-cycle valid pulse. A READ and a FETCH raised together share the one
// RAM port: the READ goes first and the FETCH is parked for one cycle.
module mem_responder #(
  parameter int NBITS = 32,
  parameter int WORD  = 32,
  parameter int MEM   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [MEM-1:0]   mem_control,
  input  logic [NBITS-1:0] mar,
  input  logic [WORD-1:0]  mdr_in,
  input  logic [NBITS-1:0] pc,
  output logic [WORD-1:0]  mdr_out,
  output logic             mdr_valid,
  output logic [7:0]       mbr_out,
  output logic             mbr_valid,
  output logic             busy,
  output logic             err,
  output logic [NBITS-1:0] ram_addr,
  output logic [WORD-1:0]  ram_data,
  output logic             ram_we,
  input  logic [WORD-1:0]  ram_q
);

  // Kind of access travelling down the response pipeline with each RAM cycle.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_WR   = 2'd1,
    TAG_RD   = 2'd2,
    TAG_FE   = 2'd3
  } tag_e;

  // ST_DEFER means a FETCH is parked in the slot and owns the next RAM cycle.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DEFER = 1'b1
  } state_e;

  logic wr_req;
  logic rd_req;
  logic fe_req;
  logic any_req;

  state_e           state_q,    state_d;
  logic [NBITS-1:0] slot_pc_q,  slot_pc_d;
  logic [NBITS-1:0] ram_addr_q, ram_addr_d;
  logic [WORD-1:0]  ram_data_q, ram_data_d;
  logic             ram_we_q,   ram_we_d;
  tag_e             tag1_q,     tag1_d;
  tag_e             tag2_q,     tag2_d;
  logic [1:0]       lane1_q,    lane1_d;
  logic [1:0]       lane2_q,    lane2_d;
  logic [WORD-1:0]  mdr_out_q,  mdr_out_d;
  logic             mdr_valid_q, mdr_valid_d;
  logic [7:0]       mbr_out_q,  mbr_out_d;
  logic             mbr_valid_q, mbr_valid_d;
  logic             busy_q,     busy_d;
  logic             err_q,      err_d;
  logic [7:0]       fetch_byte;

  assign wr_req  = mem_control[2];
  assign rd_req  = mem_control[1];
  assign fe_req  = mem_control[0];
  assign any_req = |mem_control;

  // Select the addressed byte of the returning RAM word, lane 0 being bits 7:0.
  always_comb begin
    fetch_byte = ram_q[7:0];
    case (lane2_q)
      2'd0:    fetch_byte = ram_q[7:0];
      2'd1:    fetch_byte = ram_q[15:8];
      2'd2:    fetch_byte = ram_q[23:16];
      default: fetch_byte = ram_q[31:24];
    endcase
  end

  // Issue stage: decide what the RAM port does next and whether a FETCH must be parked.
  always_comb begin
    state_d    = state_q;
    slot_pc_d  = slot_pc_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_we_d   = 1'b0;
    tag1_d     = TAG_NONE;
    lane1_d    = 2'd0;
    busy_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_DEFER: begin
        // The parked FETCH takes this cycle; anything requested meanwhile is lost.
        ram_addr_d = slot_pc_q >> 2;
        tag1_d     = TAG_FE;
        lane1_d    = slot_pc_q[1:0];
        err_d      = any_req;
        state_d    = ST_IDLE;
      end
      default: begin
        if (wr_req) begin
          // A WRITE wins the port; a READ alongside it is illegal, and a lone
          // FETCH alongside it has nowhere to go.
          ram_addr_d = mar;
          ram_data_d = mdr_in;
          ram_we_d   = 1'b1;
          tag1_d     = TAG_WR;
          err_d      = rd_req | fe_req;
        end else if (rd_req) begin
          ram_addr_d = mar;
          tag1_d     = TAG_RD;
        end else if (fe_req) begin
          ram_addr_d = pc >> 2;
          tag1_d     = TAG_FE;
          lane1_d    = pc[1:0];
        end
        if (rd_req && fe_req) begin
          slot_pc_d = pc;
          state_d   = ST_DEFER;
          busy_d    = 1'b1;
        end
      end
    endcase
  end

  // Response stage: advance the tags and capture RAM data once a tag reaches stage 2.
  always_comb begin
    tag2_d      = tag1_q;
    lane2_d     = lane1_q;
    mdr_out_d   = mdr_out_q;
    mdr_valid_d = 1'b0;
    mbr_out_d   = mbr_out_q;
    mbr_valid_d = 1'b0;
    if (tag2_q == TAG_RD) begin
      mdr_out_d   = ram_q;
      mdr_valid_d = 1'b1;
    end
    if (tag2_q == TAG_FE) begin
      mbr_out_d   = fetch_byte;
      mbr_valid_d = 1'b1;
    end
  end

  // All state; reset empties the slot and clears the tags so in-flight accesses vanish.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      slot_pc_q   <= '0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_we_q    <= 1'b0;
      tag1_q      <= TAG_NONE;
      tag2_q      <= TAG_NONE;
      lane1_q     <= 2'd0;
      lane2_q     <= 2'd0;
      mdr_out_q   <= '0;
      mdr_valid_q <= 1'b0;
      mbr_out_q   <= '0;
      mbr_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_pc_q   <= slot_pc_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      ram_we_q    <= ram_we_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      lane1_q     <= lane1_d;
      lane2_q     <= lane2_d;
      mdr_out_q   <= mdr_out_d;
      mdr_valid_q <= mdr_valid_d;
      mbr_out_q   <= mbr_out_d;
      mbr_valid_q <= mbr_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_data  = ram_data_q;
  assign ram_we    = ram_we_q;
  assign mdr_out   = mdr_out_q;
  assign mdr_valid = mdr_valid_q;
  assign mbr_out   = mbr_out_q;
  assign mbr_valid = mbr_valid_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// Drives mem_responder against a small synchronous RAM model. Directed
// sequences cover reset, latency, byte lanes, deferral and illegal requests;
// a vector table covers isolated requests; a random phase is checked against
// a request-level model of the memory and response schedule.
module tb_mem_responder;

  localparam int NBITS = 32;
  localparam int WORD  = 32;
  localparam int MEM   = 3;
  localparam int NRAND = 400;
  localparam int NVEC  = 12;

  logic             clk;
  logic             reset;
  logic [MEM-1:0]   mem_control;
  logic [NBITS-1:0] mar;
  logic [WORD-1:0]  mdr_in;
  logic [NBITS-1:0] pc;
  logic [WORD-1:0]  mdr_out;
  logic             mdr_valid;
  logic [7:0]       mbr_out;
  logic             mbr_valid;
  logic             busy;
  logic             err;
  logic [NBITS-1:0] ram_addr;
  logic [WORD-1:0]  ram_data;
  logic             ram_we;
  logic [WORD-1:0]  ram_q;

  // Bench-side RAM with a load port used while the DUT is idle
  logic [WORD-1:0] ram [0:255];
  logic            ld_en;
  logic [7:0]      ld_addr;
  logic [WORD-1:0] ld_data;

  int checks;
  int errors;

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] p;
    logic [31:0] exp_addr;
    logic        exp_err;
    logic        exp_mdr_v;
    logic [31:0] exp_mdr;
    logic        exp_mbr_v;
    logic [7:0]  exp_mbr;
  } vec_t;

  vec_t vecs [NVEC];

  // Request-level reference model state for the random phase
  logic [31:0] ref_mem   [0:255];
  bit          exp_mdr_v [0:NRAND+7];
  logic [31:0] exp_mdr_d [0:NRAND+7];
  bit          exp_mbr_v [0:NRAND+7];
  logic [7:0]  exp_mbr_d [0:NRAND+7];
  bit          exp_busy  [0:NRAND+7];
  bit          exp_err   [0:NRAND+7];
  logic [31:0] cur_mdr;
  logic [7:0]  cur_mbr;
  logic [2:0]  rctrl;
  logic [31:0] ra, rd, rp, rw;
  int          we_cnt, err_cnt, val_cnt;
  logic [7:0]  lane_exp [4];

  mem_responder #(.NBITS(NBITS), .WORD(WORD), .MEM(MEM)) dut (
    .clk(clk), .reset(reset), .mem_control(mem_control), .mar(mar),
    .mdr_in(mdr_in), .pc(pc), .mdr_out(mdr_out), .mdr_valid(mdr_valid),
    .mbr_out(mbr_out), .mbr_valid(mbr_valid), .busy(busy), .err(err),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM: read data appears the cycle after the address is sampled
  always @(posedge clk) begin
    if (ld_en) ram[ld_addr] <= ld_data;
    else if (ram_we) ram[ram_addr[7:0]] <= ram_data;
    ram_q <= ram[ram_addr[7:0]];
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One request per cycle: drive just after the edge, return mid-cycle for sampling
  task automatic applyStimulus(input logic [2:0] ctrl, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] p);
    @(posedge clk);
    #1;
    mem_control = ctrl;
    mar         = a;
    mdr_in      = d;
    pc          = p;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(3'b000, 0, 0, 0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_control = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic loadRam(input bit randomize);
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      ld_en   = 1'b1;
      ld_addr = i[7:0];
      if (randomize) ld_data = $urandom;
      else if (i == 5) ld_data = 32'hF0F0F0F0;
      else if (i == 1) ld_data = 32'h44332211;
      else ld_data = 32'h0;
      ref_mem[i] = ld_data;
    end
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    mem_control = '0;
    mar = '0;
    mdr_in = '0;
    pc = '0;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    lane_exp[0] = 8'h11; lane_exp[1] = 8'h22; lane_exp[2] = 8'h33; lane_exp[3] = 8'h44;

    loadRam(1'b0);
    doReset();

    // Reset state
    checkOutput("rst_mdr_out", mdr_out, 0);
    checkOutput("rst_mdr_valid", {31'b0, mdr_valid}, 0);
    checkOutput("rst_mbr_out", {24'b0, mbr_out}, 0);
    checkOutput("rst_mbr_valid", {31'b0, mbr_valid}, 0);
    checkOutput("rst_busy", {31'b0, busy}, 0);
    checkOutput("rst_err", {31'b0, err}, 0);
    checkOutput("rst_ram_addr", ram_addr, 0);
    checkOutput("rst_ram_data", ram_data, 0);
    checkOutput("rst_ram_we", {31'b0, ram_we}, 0);

    // READ word 5: latency 3, then held
    applyStimulus(3'b010, 5, 0, 0);
    idle(1);
    checkOutput("rd5_addr", ram_addr, 5);
    checkOutput("rd5_we", {31'b0, ram_we}, 0);
    idle(1);
    checkOutput("rd5_early_valid", {31'b0, mdr_valid}, 0);
    idle(1);
    checkOutput("rd5_valid", {31'b0, mdr_valid}, 1);
    checkOutput("rd5_data", mdr_out, 32'hF0F0F0F0);
    for (int i = 4; i <= 10; i++) begin
      idle(1);
      checkOutput($sformatf("rd5_hold_k%0d", i), mdr_out, 32'hF0F0F0F0);
      checkOutput($sformatf("rd5_novalid_k%0d", i), {31'b0, mdr_valid}, 0);
    end

    // WRITE 9 then READ 9 back to back
    we_cnt = 0;
    applyStimulus(3'b100, 9, 32'hDEADBEEF, 0);
    we_cnt += int'(ram_we);
    applyStimulus(3'b010, 9, 0, 0);
    we_cnt += int'(ram_we);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      we_cnt += int'(ram_we);
      if (i == 2) begin
        checkOutput("wr9rd9_valid", {31'b0, mdr_valid}, 1);
        checkOutput("wr9rd9_data", mdr_out, 32'hDEADBEEF);
      end
    end
    checkOutput("wr9_we_cycles", we_cnt, 1);

    // FETCH pc 4..7 consecutively: one byte lane per cycle
    for (int j = 0; j < 7; j++) begin
      if (j < 4) applyStimulus(3'b001, 0, 0, 4 + j);
      else idle(1);
      if (j >= 3) begin
        checkOutput($sformatf("lane%0d_valid", j - 3), {31'b0, mbr_valid}, 1);
        checkOutput($sformatf("lane%0d_byte", j - 3), {24'b0, mbr_out}, {24'b0, lane_exp[j-3]});
      end
    end

    // READ 5 + FETCH 6 together, then a READ while busy
    idle(1);
    applyStimulus(3'b011, 5, 0, 6);
    applyStimulus(3'b010, 9, 0, 0);
    checkOutput("rf_busy_k1", {31'b0, busy}, 1);
    checkOutput("rf_err_k1", {31'b0, err}, 0);
    idle(1);
    checkOutput("rf_err_k2", {31'b0, err}, 1);
    checkOutput("rf_busy_k2", {31'b0, busy}, 0);
    idle(1);
    checkOutput("rf_mdr_valid_k3", {31'b0, mdr_valid}, 1);
    checkOutput("rf_mdr_k3", mdr_out, 32'hF0F0F0F0);
    checkOutput("rf_mbr_valid_k3", {31'b0, mbr_valid}, 0);
    idle(1);
    checkOutput("rf_mbr_valid_k4", {31'b0, mbr_valid}, 1);
    checkOutput("rf_mbr_k4", {24'b0, mbr_out}, 32'h33);
    checkOutput("rf_ignored_read_k4", {31'b0, mdr_valid}, 0);
    idle(1);
    checkOutput("rf_ignored_read_k5", {31'b0, mdr_valid}, 0);

    // WRITE+READ together: write happens, err once, no read response
    idle(2);
    err_cnt = 0;
    val_cnt = 0;
    we_cnt = 0;
    applyStimulus(3'b110, 12, 32'hCAFEF00D, 0);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      err_cnt += int'(err);
      val_cnt += int'(mdr_valid);
      we_cnt  += int'(ram_we);
    end
    checkOutput("wr_rd_err_pulses", err_cnt, 1);
    checkOutput("wr_rd_no_mdr_valid", val_cnt, 0);
    checkOutput("wr_rd_we_cycles", we_cnt, 1);
    applyStimulus(3'b010, 12, 0, 0);
    idle(3);
    checkOutput("wr_rd_written", mdr_out, 32'hCAFEF00D);

    // Reset in the middle of a READ discards it
    applyStimulus(3'b010, 5, 0, 0);
    idle(1);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    val_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      val_cnt += int'(mdr_valid);
      checkOutput($sformatf("midrst_mdr_%0d", i), mdr_out, 0);
    end
    checkOutput("midrst_no_valid", val_cnt, 0);

    // Isolated requests: err at k+1, address at k+1, responses at k+3
    vecs[0]  = '{3'b010, 5,  0, 0,  5, 0, 1, 32'hF0F0F0F0, 0, 8'h00};
    vecs[1]  = '{3'b001, 0,  0, 4,  1, 0, 0, 32'hF0F0F0F0, 1, 8'h11};
    vecs[2]  = '{3'b001, 0,  0, 7,  1, 0, 0, 32'hF0F0F0F0, 1, 8'h44};
    vecs[3]  = '{3'b100, 20, 32'h12345678, 0, 20, 0, 0, 32'hF0F0F0F0, 0, 8'h44};
    vecs[4]  = '{3'b010, 20, 0, 0, 20, 0, 1, 32'h12345678, 0, 8'h44};
    vecs[5]  = '{3'b110, 21, 32'hA5A55A5A, 0, 21, 1, 0, 32'h12345678, 0, 8'h44};
    vecs[6]  = '{3'b010, 21, 0, 0, 21, 0, 1, 32'hA5A55A5A, 0, 8'h44};
    vecs[7]  = '{3'b001, 0,  0, 32'h56, 21, 0, 0, 32'hA5A55A5A, 1, 8'hA5};
    vecs[8]  = '{3'b011, 9,  0, 32'h50, 9, 0, 1, 32'hDEADBEEF, 0, 8'hA5};
    vecs[9]  = '{3'b111, 22, 32'h0BADCAFE, 32'h58, 22, 1, 0, 32'hDEADBEEF, 0, 8'h78};
    vecs[10] = '{3'b001, 0,  0, 32'h5B, 22, 0, 0, 32'hDEADBEEF, 1, 8'h0B};
    vecs[11] = '{3'b001, 0,  0, 32'hFFFFFFFF, 32'h3FFFFFFF, 0, 0, 32'hDEADBEEF, 1, 8'h00};
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].ctrl, vecs[i].a, vecs[i].d, vecs[i].p);
      idle(1);
      checkOutput($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
      checkOutput($sformatf("vec%0d_addr", i), ram_addr, vecs[i].exp_addr);
      idle(2);
      checkOutput($sformatf("vec%0d_mdr_valid", i), {31'b0, mdr_valid}, {31'b0, vecs[i].exp_mdr_v});
      checkOutput($sformatf("vec%0d_mdr", i), mdr_out, vecs[i].exp_mdr);
      checkOutput($sformatf("vec%0d_mbr_valid", i), {31'b0, mbr_valid}, {31'b0, vecs[i].exp_mbr_v});
      checkOutput($sformatf("vec%0d_mbr", i), {24'b0, mbr_out}, {24'b0, vecs[i].exp_mbr});
      idle(1);
    end

    // Random phase against the request-level model
    loadRam(1'b1);
    doReset();
    for (int i = 0; i < NRAND + 8; i++) begin
      exp_mdr_v[i] = 0; exp_mdr_d[i] = 0;
      exp_mbr_v[i] = 0; exp_mbr_d[i] = 0;
      exp_busy[i]  = 0; exp_err[i]   = 0;
    end
    cur_mdr = 0;
    cur_mbr = 0;
    for (int c = 0; c < NRAND; c++) begin
      rctrl = 3'($urandom_range(0, 7));
      if (rctrl == 3'b101) rctrl = 3'b100;
      if ($urandom_range(0, 3) == 0 || c >= NRAND - 5) rctrl = 3'b000;
      ra = $urandom_range(0, 15);
      rd = $urandom;
      rp = $urandom_range(0, 63);
      if (exp_busy[c]) begin
        if (rctrl != 3'b000) exp_err[c+1] = 1;
      end else begin
        if (rctrl[2]) begin
          ref_mem[ra[7:0]] = rd;
          if (rctrl[1] || rctrl[0]) exp_err[c+1] = 1;
        end else if (rctrl[1]) begin
          exp_mdr_v[c+3] = 1;
          exp_mdr_d[c+3] = ref_mem[ra[7:0]];
        end
        if (rctrl[1] && rctrl[0]) begin
          exp_busy[c+1]  = 1;
          rw             = ref_mem[rp / 4];
          exp_mbr_v[c+4] = 1;
          exp_mbr_d[c+4] = 8'((rw >> (8 * (rp % 4))) & 32'hFF);
        end else if (rctrl[0] && !rctrl[2]) begin
          rw             = ref_mem[rp / 4];
          exp_mbr_v[c+3] = 1;
          exp_mbr_d[c+3] = 8'((rw >> (8 * (rp % 4))) & 32'hFF);
        end
      end
      applyStimulus(rctrl, ra, rd, rp);
      if (exp_mdr_v[c]) cur_mdr = exp_mdr_d[c];
      if (exp_mbr_v[c]) cur_mbr = exp_mbr_d[c];
      checkOutput($sformatf("rnd%0d_mdr_valid", c), {31'b0, mdr_valid}, {31'b0, exp_mdr_v[c]});
      checkOutput($sformatf("rnd%0d_mdr", c), mdr_out, cur_mdr);
      checkOutput($sformatf("rnd%0d_mbr_valid", c), {31'b0, mbr_valid}, {31'b0, exp_mbr_v[c]});
      checkOutput($sformatf("rnd%0d_mbr", c), {24'b0, mbr_out}, {24'b0, cur_mbr});
      checkOutput($sformatf("rnd%0d_busy", c), {31'b0, busy}, {31'b0, exp_busy[c]});
      checkOutput($sformatf("rnd%0d_err", c), {31'b0, err}, {31'b0, exp_err[c]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
